// File: rtl/receive_buff_param.sv
// Tag-matched receive buffer with a parametric number of entries.
// Packets are written into the lowest free entry. A lookup by tag returns the
// lowest-index matching entry and frees it. Reads and writes may be issued in
// the same cycle.
// Optional build macro: RB_WR_BYPASS_EN. When it is defined, a same-cycle
// write whose tag equals the lookup tag is forwarded to the read if no stored
// entry matches, and that write is then not stored.
module receive_buff_param #(
  parameter int unsigned NUM_ENTRY  = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAG_WIDTH  = 8,
  localparam int unsigned CNT_WIDTH = $clog2(NUM_ENTRY + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wen_i,
  input  logic [TAG_WIDTH-1:0]  wtag_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  ren_i,
  input  logic [TAG_WIDTH-1:0]  rtag_i,
  output logic                  rvalid_o,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  wr_drop_o
);

  localparam int unsigned IdxW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

  // Per-entry state. Only the valid bits are reset.
  logic [NUM_ENTRY-1:0]  valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_ENTRY];
  logic [DATA_WIDTH-1:0] data_q [NUM_ENTRY];

  // Occupancy, kept equal to the popcount of valid_q.
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  // Registered read result and drop flag.
  logic                  rvalid_q, rvalid_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_drop_q, wr_drop_d;

  // Lookup and allocation decode, all on pre-edge state.
  logic [NUM_ENTRY-1:0]  match;
  logic                  hit_any;
  logic [IdxW-1:0]       hit_idx;
  logic                  free_any;
  logic [IdxW-1:0]       free_idx;
  logic                  bypass;
  logic                  rd_hit;
  logic                  wr_acc;

  // Tag compare against every valid entry.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      match[i] = valid_q[i] && (tag_q[i] == rtag_i);
    end
  end

  // Lowest-index matching entry; scanning downwards leaves the lowest one last.
  always_comb begin
    hit_any = |match;
    hit_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_idx = IdxW'(i);
      end
    end
  end

  // Lowest-index free entry. Entries freed by a same-cycle hit are not seen
  // here, so they are never reused in that cycle.
  always_comb begin
    free_any = ~&valid_q;
    free_idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IdxW'(i);
      end
    end
  end

`ifdef RB_WR_BYPASS_EN
  // Forward the incoming packet straight to the lookup when nothing stored matches.
  assign bypass = ren_i && wen_i && (rtag_i == wtag_i) && !hit_any;
`else
  assign bypass = 1'b0;
`endif

  assign rd_hit = ren_i && hit_any;
  // A forwarded write is consumed by the read and never allocated or dropped.
  assign wr_acc = wen_i && free_any && !bypass;

  // Next-state for valid bits, count and the registered outputs.
  always_comb begin
    valid_d    = valid_q;
    count_d    = count_q;
    rvalid_d   = 1'b0;
    hit_d      = hit_q;
    data_out_d = data_out_q;
    wr_drop_d  = wen_i && !free_any && !bypass;

    // The hit entry was valid and the allocated one was free, so they differ.
    if (rd_hit) begin
      valid_d[hit_idx] = 1'b0;
    end
    if (wr_acc) begin
      valid_d[free_idx] = 1'b1;
    end
    count_d = count_q + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(rd_hit);

    if (ren_i) begin
      rvalid_d = 1'b1;
      if (hit_any) begin
        hit_d      = 1'b1;
        data_out_d = data_q[hit_idx];
      end else if (bypass) begin
        hit_d      = 1'b1;
        data_out_d = data_in_i;
      end else begin
        hit_d      = 1'b0;
        data_out_d = '0;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      count_q    <= '0;
      rvalid_q   <= 1'b0;
      hit_q      <= 1'b0;
      data_out_q <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      rvalid_q   <= rvalid_d;
      hit_q      <= hit_d;
      data_out_q <= data_out_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Tag and payload storage; not reset because valid_q qualifies it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) begin
      tag_q[free_idx]  <= wtag_i;
      data_q[free_idx] <= data_in_i;
    end
  end

  assign rvalid_o   = rvalid_q;
  assign hit_o      = hit_q;
  assign data_out_o = data_out_q;
  assign wr_drop_o  = wr_drop_q;
  assign count_o    = count_q;
  assign empty_o    = ~|valid_q;
  assign full_o     = &valid_q;

endmodule

// File: tb/tb_receive_buff_param.sv
// Directed self-checking bench for receive_buff_param (default parameters).
// Expected values are hand-computed; RB_WR_BYPASS_EN selects the matching set.
module tb_receive_buff_param;

  localparam int unsigned NumEntry = 8;
  localparam int unsigned DataW    = 16;
  localparam int unsigned TagW     = 8;
  localparam int unsigned CntW     = $clog2(NumEntry + 1);

  logic             clk;
  logic             rst;
  logic             wen;
  logic [TagW-1:0]  wtag;
  logic [DataW-1:0] data_in;
  logic             ren;
  logic [TagW-1:0]  rtag;
  logic             rvalid;
  logic             hit;
  logic [DataW-1:0] data_out;
  logic             empty;
  logic             full;
  logic [CntW-1:0]  count;
  logic             wr_drop;

  int checks;
  int failures;

  receive_buff_param #(
    .NUM_ENTRY (NumEntry),
    .DATA_WIDTH(DataW),
    .TAG_WIDTH (TagW)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wen_i     (wen),
    .wtag_i    (wtag),
    .data_in_i (data_in),
    .ren_i     (ren),
    .rtag_i    (rtag),
    .rvalid_o  (rvalid),
    .hit_o     (hit),
    .data_out_o(data_out),
    .empty_o   (empty),
    .full_o    (full),
    .count_o   (count),
    .wr_drop_o (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic [TagW-1:0] wt,
                      input logic [DataW-1:0] d, input logic rd, input logic [TagW-1:0] rt);
    rst     = r;
    wen     = w;
    wtag    = wt;
    data_in = d;
    ren     = rd;
    rtag    = rt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic v, input logic h,
                        input logic [DataW-1:0] d, input int cnt);
    chk({name, ".rvalid"}, 32'(rvalid), 32'(v));
    chk({name, ".hit"}, 32'(hit), 32'(h));
    chk({name, ".data"}, 32'(data_out), 32'(d));
    chk({name, ".count"}, 32'(count), 32'(cnt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0; wen = 1'b0; ren = 1'b0; wtag = '0; rtag = '0; data_in = '0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk_rd("rst", 1'b0, 1'b0, 16'h0000, 0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.wr_drop", 32'(wr_drop), 32'd0);

    // Single write then read
    step(1'b0, 1'b1, 8'h05, 16'h1234, 1'b0, 8'h00);
    chk("wr1.count", 32'(count), 32'd1);
    chk("wr1.empty", 32'(empty), 32'd0);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h05);
    chk_rd("rd1", 1'b1, 1'b1, 16'h1234, 0);
    chk("rd1.empty", 32'(empty), 32'd1);

    // Idle: rvalid drops, hit/data hold
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk_rd("idle", 1'b0, 1'b1, 16'h1234, 0);

    // Fill with tags 0..7
    for (int i = 0; i < NumEntry; i++) begin
      step(1'b0, 1'b1, 8'(i), 16'(16'h0100 + i), 1'b0, 8'h00);
    end
    chk("fill.count", 32'(count), 32'd8);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.wr_drop", 32'(wr_drop), 32'd0);

    // Ninth write is dropped
    step(1'b0, 1'b1, 8'h20, 16'h2020, 1'b0, 8'h00);
    chk("drop.wr_drop", 32'(wr_drop), 32'd1);
    chk("drop.count", 32'(count), 32'd8);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk("drop.pulse_end", 32'(wr_drop), 32'd0);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h20);
    chk_rd("drop.miss", 1'b1, 1'b0, 16'h0000, 8);

    // Full: hit on tag 3 with concurrent write, write still dropped
    step(1'b0, 1'b1, 8'h30, 16'h3030, 1'b1, 8'h03);
    chk_rd("fullrw", 1'b1, 1'b1, 16'h0103, 7);
    chk("fullrw.wr_drop", 32'(wr_drop), 32'd1);
    chk("fullrw.full", 32'(full), 32'd0);
    step(1'b0, 1'b1, 8'h30, 16'h3030, 1'b0, 8'h00);
    chk("refill.count", 32'(count), 32'd8);
    chk("refill.full", 32'(full), 32'd1);
    chk("refill.wr_drop", 32'(wr_drop), 32'd0);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h30);
    chk_rd("rd30", 1'b1, 1'b1, 16'h3030, 7);
    step(1'b0, 1'b1, 8'h31, 16'h3131, 1'b0, 8'h00);
    chk("refill2.count", 32'(count), 32'd8);

    // Same-tag read/write while full, tag absent
    step(1'b0, 1'b1, 8'h40, 16'h4444, 1'b1, 8'h40);
`ifdef RB_WR_BYPASS_EN
    chk_rd("byp_full", 1'b1, 1'b1, 16'h4444, 8);
    chk("byp_full.wr_drop", 32'(wr_drop), 32'd0);
`else
    chk_rd("byp_full", 1'b1, 1'b0, 16'h0000, 8);
    chk("byp_full.wr_drop", 32'(wr_drop), 32'd1);
`endif

    // Duplicate tags: lowest entry returned first, one invalidated per hit
    step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    chk("rst2.count", 32'(count), 32'd0);
    step(1'b0, 1'b1, 8'h07, 16'hAAAA, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h07, 16'hBBBB, 1'b0, 8'h00);
    chk("dup.count", 32'(count), 32'd2);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h07);
    chk_rd("dup.rd1", 1'b1, 1'b1, 16'hAAAA, 1);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h07);
    chk_rd("dup.rd2", 1'b1, 1'b1, 16'hBBBB, 0);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h07);
    chk_rd("dup.rd3", 1'b1, 1'b0, 16'h0000, 0);

    // Same-tag read/write on an empty buffer
    step(1'b0, 1'b1, 8'h09, 16'h5A5A, 1'b1, 8'h09);
`ifdef RB_WR_BYPASS_EN
    chk_rd("byp", 1'b1, 1'b1, 16'h5A5A, 0);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h09);
    chk_rd("byp.after", 1'b1, 1'b0, 16'h0000, 0);
`else
    chk_rd("byp", 1'b1, 1'b0, 16'h0000, 1);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h09);
    chk_rd("byp.after", 1'b1, 1'b1, 16'h5A5A, 0);
`endif

    // Lookup issued in the reset cycle yields nothing
    step(1'b0, 1'b1, 8'h0C, 16'hCCCC, 1'b0, 8'h00);
    chk("rstrd.pre", 32'(count), 32'd1);
    step(1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h0C);
    chk_rd("rstrd", 1'b0, 1'b0, 16'h0000, 0);
    chk("rstrd.empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h0C);
    chk_rd("rstrd.miss", 1'b1, 1'b0, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/receive_buff_param.md
Name: receive_buff_param

Overview:
- Parametrised tag-matched receive buffer for the tile input path. Replaces the fixed 8-entry buffer.
- Packets arrive with a tag and are stored in any free entry. Consumers retrieve a packet by tag, and the entry is freed on hit.
- Additions over the fixed version: parametric depth; concurrent read and write in the same cycle; single-entry invalidation on multiple matches; defined miss data; occupancy count; write-drop flag.

Parameters:
- NUM_ENTRY, 8, number of entries (>=2).
- DATA_WIDTH, 16, payload bits per entry.
- TAG_WIDTH, 8, tag bits per entry.
- CNT_WIDTH (localparam), $clog2(NUM_ENTRY+1), width of the count output.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- wen  in  1  write request.
- wtag  in  TAG_WIDTH  tag of incoming packet.
- data_in  in  DATA_WIDTH  payload of incoming packet.
- ren  in  1  read (lookup) request.
- rtag  in  TAG_WIDTH  tag to look up.
- rvalid  out  1  read result valid (one-cycle pulse).
- hit  out  1  read result: tag found.
- data_out  out  DATA_WIDTH  read result payload.
- empty  out  1  no valid entries.
- full  out  1  all entries valid.
- count  out  CNT_WIDTH  number of valid entries.
- wr_drop  out  1  pulse: write was rejected because the buffer was full.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clock edge): all valid bits 0, rvalid=0, hit=0, data_out=0, wr_drop=0, count=0. Hence empty=1 and full=0. Data and tag storage is not reset.
- rst has priority over ren and wen. A lookup issued in the reset cycle produces no result, so rvalid=0 in the following cycle.
- empty, full and count reflect registered state only. count is held in a register and must always equal the popcount of the valid bits.
- Read, lookup in cycle N:
  - match[i] = valid[i] & (tag[i]==rtag), evaluated on pre-edge state.
  - Result is registered and visible in cycle N+1: rvalid=1, hit=|match.
  - On hit: data_out = data of the lowest-index matching entry. Only that entry is invalidated; other duplicates remain valid.
  - On miss: hit=0, data_out=0, no state change.
  - With ren=0: rvalid=0, and hit/data_out hold their previous values.
- Write in cycle N:
  - If full is 0 (pre-edge), the packet is stored into the lowest-index entry with valid=0 (pre-edge) and that entry's valid is set.
  - If full is 1, the packet is discarded and wr_drop=1 in cycle N+1 for one cycle.
- Simultaneous ren and wen are both serviced in the same cycle.
  - The write allocates only from entries that were free before the edge, so an entry freed by the concurrent hit is not reused in that cycle.
  - The lookup does not see the same-cycle write; the exception is the bypass below.
  - A write while full is dropped even if the concurrent read hits.
- count update: next = count + (write accepted) - (read hit). Range 0..NUM_ENTRY; it never wraps.
- No state machine beyond the per-entry valid bits and the output registers. All priority selection is parametric (loops/generate); no hard-coded entry count.

Optional Feature:
- Macro: RB_WR_BYPASS_EN.
- Defined: when ren & wen in the same cycle, rtag==wtag, and no stored entry matches, the write is forwarded to the read.
  - Cycle N+1: rvalid=1, hit=1, data_out=data_in.
  - The write is not allocated; count is unchanged.
  - The bypass applies even when full=1, and wr_drop stays 0 in that case.
- Undefined: no forwarding. The read misses (hit=0, data_out=0) and the write allocates normally, or is dropped if full.

Test Plan:
- Reset, then write tag 0x05 / data 0x1234 -> count=1, empty=0. Read tag 0x05 -> next cycle rvalid=1, hit=1, data_out=0x1234, count=0, empty=1.
- Write 8 distinct tags (NUM_ENTRY=8) -> full=1, count=8. Ninth write -> wr_drop=1 for one cycle, count stays 8, and the dropped tag later reads as a miss.
- Write tag 0x07 twice with data 0xAAAA then 0xBBBB -> first read of 0x07 returns 0xAAAA with count 2->1; second read returns 0xBBBB; third read: hit=0, data_out=0.
- Buffer full, same-cycle read tag 0x03 (present) + write of a new tag -> read hits, write dropped, wr_drop=1, count goes 8->7. Write again next cycle -> accepted into the freed entry, count=8.
- Same-cycle ren/wen, both tag 0x09, 0x09 absent, data 0x5A5A -> with RB_WR_BYPASS_EN: hit=1, data_out=0x5A5A, count unchanged. Without it: hit=0, then a later read of 0x09 returns 0x5A5A.
- Issue read of a stored tag with rst=1 in the same cycle -> next cycle rvalid=0, count=0, empty=1, and the tag subsequently misses.
